// File: rtl/beehive_in_convert.sv
// Store-and-forward bridge from the Corundum AXIS RX stream (wide, little-endian, tkeep) to the
// Beehive MAC-side RX interface (big-endian, frame_size on startframe, padbytes on endframe).
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MTU_SIZE
`define MTU_SIZE 1500
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module beehive_in_convert #(
   parameter int unsigned AXIS_SYNC_DATA_WIDTH    = 512,
   parameter int unsigned AXIS_SYNC_KEEP_WIDTH    = AXIS_SYNC_DATA_WIDTH / 8,
   parameter int unsigned AXIS_SYNC_RX_USER_WIDTH = 1,
   parameter int unsigned BUF_BEATS               = 32,
   parameter int unsigned LEN_FIFO_DEPTH          = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               app_axis_sync_rx_tvalid,
   input  logic [AXIS_SYNC_DATA_WIDTH-1:0]    app_axis_sync_rx_tdata,
   input  logic [AXIS_SYNC_KEEP_WIDTH-1:0]    app_axis_sync_rx_tkeep,
   input  logic                               app_axis_sync_rx_tlast,
   input  logic [AXIS_SYNC_RX_USER_WIDTH-1:0] app_axis_sync_rx_tuser,
   output logic                               app_axis_sync_rx_tready,
   output logic                               convert_dst_rx_val,
   output logic                               convert_dst_rx_startframe,
   output logic [`MTU_SIZE_W-1:0]             convert_dst_rx_frame_size,
   output logic                               convert_dst_rx_endframe,
   output logic [`MAC_INTERFACE_W-1:0]        convert_dst_rx_data,
   output logic [`MAC_PADBYTES_W-1:0]         convert_dst_rx_padbytes,
   input  logic                               dst_convert_rx_rdy
);
   localparam int unsigned DW      = AXIS_SYNC_DATA_WIDTH;
   localparam int unsigned KW      = AXIS_SYNC_KEEP_WIDTH;
   localparam int unsigned MW      = `MAC_INTERFACE_W;
   localparam int unsigned NB      = MW / 8;
   localparam int unsigned OUT_ELS = DW / MW;
   localparam int unsigned EL_W    = (OUT_ELS > 1) ? $clog2(OUT_ELS) : 1;
   localparam int unsigned PTR_W   = $clog2(BUF_BEATS);
   localparam int unsigned LF_W    = $clog2(LEN_FIFO_DEPTH);
   localparam int unsigned SZ_W    = `MTU_SIZE_W;
   localparam int unsigned PAD_W   = `MAC_PADBYTES_W;
   localparam int unsigned KC_W    = $clog2(KW + 1);
   localparam int unsigned MTU     = `MTU_SIZE;

   if ((DW % MW) != 0 || DW < MW) begin : g_width_check
      $error("AXIS_SYNC_DATA_WIDTH must be a multiple of MAC_INTERFACE_W");
   end

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   logic [DW-1:0]   buf_mem [BUF_BEATS];
   logic [PTR_W:0]  wr_spec_q, wr_commit_q, rd_ptr_q, wr_spec_inc, rd_next;
   logic [SZ_W-1:0] byte_cnt_q, cnt_next;
   logic [SZ_W:0]   cnt_sum;
   logic            drop_q, accept, buf_full, frame_bad;
   logic [DW-1:0]   in_flip;
   logic [KC_W-1:0] keep_cnt;

   logic [SZ_W-1:0] lf_size  [LEN_FIFO_DEPTH];
   logic [KC_W-1:0] lf_last  [LEN_FIFO_DEPTH];
   logic [PTR_W:0]  lf_beats [LEN_FIFO_DEPTH];
   logic [LF_W:0]   lf_wr_q, lf_rd_q;
   logic            lf_full, lf_empty, lf_push, lf_pop;
   logic [KC_W-1:0] head_last;
   logic [KC_W:0]   head_els_raw, head_els;
   logic [PAD_W-1:0] head_pad;

   state_e          state_q, state_d;
   logic [DW-1:0]   beat_q;
   logic [MW-1:0]   el_data;
   logic [EL_W-1:0] el_q;
   logic [KC_W:0]   last_els_q;
   logic [PTR_W:0]  beats_left_q;
   logic [SZ_W-1:0] frame_size_q;
   logic [PAD_W-1:0] pad_q;
   logic            first_q, fire, last_beat, is_end, el_end;
   logic            load_frame, load_beat, rd_adv;
   logic [PTR_W-1:0] ld_idx;

   // Byte 0 lands in the MSB byte; popcount of tkeep is order-independent.
   always_comb begin
      in_flip  = '0;
      keep_cnt = '0;
      for (int i = 0; i < KW; i++) begin
         in_flip[(KW-1-i)*8 +: 8] = app_axis_sync_rx_tdata[i*8 +: 8];
         keep_cnt = keep_cnt + KC_W'(app_axis_sync_rx_tkeep[i]);
      end
   end

   assign buf_full  = (wr_spec_q - rd_ptr_q) == (PTR_W+1)'(BUF_BEATS);
   assign app_axis_sync_rx_tready = rst & (drop_q | (!buf_full & !lf_full));
   assign accept    = app_axis_sync_rx_tvalid & app_axis_sync_rx_tready;
   assign cnt_sum   = {1'b0, byte_cnt_q} + (SZ_W+1)'(keep_cnt);
   assign cnt_next  = (cnt_sum > (SZ_W+1)'(MTU + 1)) ? SZ_W'(MTU + 1) : cnt_sum[SZ_W-1:0];
   assign frame_bad = drop_q | app_axis_sync_rx_tuser[0] | (cnt_next == '0) |
                      (cnt_next > SZ_W'(MTU));
   assign wr_spec_inc = wr_spec_q + (PTR_W+1)'(1);
   assign lf_push   = accept & app_axis_sync_rx_tlast & !frame_bad;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         byte_cnt_q  <= '0;
         drop_q      <= 1'b0;
      end else if (accept) begin
         if (app_axis_sync_rx_tlast) begin
            byte_cnt_q <= '0;
            drop_q     <= 1'b0;
            if (frame_bad) begin
               wr_spec_q <= wr_commit_q;
            end else begin
               wr_spec_q   <= wr_spec_inc;
               wr_commit_q <= wr_spec_inc;
            end
         end else begin
            byte_cnt_q <= cnt_next;
            if (!drop_q) wr_spec_q <= wr_spec_inc;
            if (cnt_next > SZ_W'(MTU)) drop_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !drop_q) buf_mem[wr_spec_q[PTR_W-1:0]] <= in_flip;
   end

   assign lf_empty = lf_wr_q == lf_rd_q;
   assign lf_full  = (lf_wr_q - lf_rd_q) == (LF_W+1)'(LEN_FIFO_DEPTH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         lf_wr_q <= '0;
         lf_rd_q <= '0;
      end else begin
         if (lf_push) lf_wr_q <= lf_wr_q + (LF_W+1)'(1);
         if (lf_pop)  lf_rd_q <= lf_rd_q + (LF_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (lf_push) begin
         lf_size[lf_wr_q[LF_W-1:0]]  <= cnt_next;
         lf_last[lf_wr_q[LF_W-1:0]]  <= keep_cnt;
         lf_beats[lf_wr_q[LF_W-1:0]] <= wr_spec_inc - wr_commit_q;
      end
   end

   // Element count and pad of the head frame's last beat, precomputed for the load.
   assign head_last    = lf_last[lf_rd_q[LF_W-1:0]];
   assign head_els_raw = ({1'b0, head_last} + (KC_W+1)'(NB - 1)) / (KC_W+1)'(NB);
   assign head_els     = (head_els_raw == '0) ? (KC_W+1)'(1) : head_els_raw;
   assign head_pad     = PAD_W'(head_els * (KC_W+1)'(NB) - {1'b0, head_last});

   assign rd_next   = rd_ptr_q + (PTR_W+1)'(1);
   assign ld_idx    = (state_q == StIdle) ? rd_ptr_q[PTR_W-1:0] : rd_next[PTR_W-1:0];
   assign fire      = (state_q == StSend) & dst_convert_rx_rdy;
   assign last_beat = beats_left_q == (PTR_W+1)'(1);
   assign is_end    = last_beat & (((KC_W+1)'(el_q) + (KC_W+1)'(1)) == last_els_q);
   assign el_end    = is_end | (!last_beat & (el_q == EL_W'(OUT_ELS - 1)));

   always_comb begin
      state_d    = state_q;
      load_frame = 1'b0;
      load_beat  = 1'b0;
      rd_adv     = 1'b0;
      lf_pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!lf_empty) begin
               load_frame = 1'b1;
               lf_pop     = 1'b1;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (fire && el_end) begin
               rd_adv = 1'b1;
               if (!last_beat) begin
                  load_beat = 1'b1;
               end else if (!lf_empty) begin
                  load_frame = 1'b1;
                  lf_pop     = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         rd_ptr_q     <= '0;
         beat_q       <= '0;
         el_q         <= '0;
         last_els_q   <= '0;
         beats_left_q <= '0;
         frame_size_q <= '0;
         pad_q        <= '0;
         first_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rd_adv) rd_ptr_q <= rd_next;
         if (fire) begin
            first_q <= 1'b0;
            el_q    <= el_q + EL_W'(1);
         end
         if (load_beat) begin
            beat_q       <= buf_mem[ld_idx];
            beats_left_q <= beats_left_q - (PTR_W+1)'(1);
            el_q         <= '0;
         end
         if (load_frame) begin
            beat_q       <= buf_mem[ld_idx];
            beats_left_q <= lf_beats[lf_rd_q[LF_W-1:0]];
            frame_size_q <= lf_size[lf_rd_q[LF_W-1:0]];
            last_els_q   <= head_els;
            pad_q        <= head_pad;
            el_q         <= '0;
            first_q      <= 1'b1;
         end
      end
   end

   always_comb begin
      el_data = '0;
      for (int e = 0; e < OUT_ELS; e++) begin
         if (el_q == EL_W'(e)) el_data = beat_q[(OUT_ELS-1-e)*MW +: MW];
      end
   end

   assign convert_dst_rx_val        = state_q == StSend;
   assign convert_dst_rx_startframe = convert_dst_rx_val & first_q;
   assign convert_dst_rx_endframe   = convert_dst_rx_val & is_end;
   assign convert_dst_rx_frame_size = convert_dst_rx_val ? frame_size_q : '0;
   assign convert_dst_rx_data       = convert_dst_rx_val ? el_data : '0;
   assign convert_dst_rx_padbytes   = convert_dst_rx_endframe ? pad_q : '0;

endmodule

// File: tb/tb_beehive_in_convert.sv
// Bench for beehive_in_convert: random frames in, expected Beehive beats derived from the frame
// bytes, checked on every valid output cycle (which also covers stability while stalled).
module tb_beehive_in_convert;
   localparam int MTU = 1500;

   typedef struct {
      logic [255:0] data;
      logic         sf;
      logic         ef;
      logic [15:0]  fsize;
      logic [4:0]   pad;
   } exp_t;

   logic         clk, rst;
   logic         tvalid, tlast, tready, rdy;
   logic [511:0] tdata;
   logic [63:0]  tkeep;
   logic [0:0]   tuser;
   logic         val, sf, ef;
   logic [15:0]  fsize;
   logic [255:0] data;
   logic [4:0]   pad;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   tlast_cyc = 0;
   int   start_cyc = 0;
   bit   start_seen = 0;
   int   rdy_mode = 1;
   exp_t expq[$];

   beehive_in_convert dut (
      .clk                       (clk),
      .rst                       (rst),
      .app_axis_sync_rx_tvalid   (tvalid),
      .app_axis_sync_rx_tdata    (tdata),
      .app_axis_sync_rx_tkeep    (tkeep),
      .app_axis_sync_rx_tlast    (tlast),
      .app_axis_sync_rx_tuser    (tuser),
      .app_axis_sync_rx_tready   (tready),
      .convert_dst_rx_val        (val),
      .convert_dst_rx_startframe (sf),
      .convert_dst_rx_frame_size (fsize),
      .convert_dst_rx_endframe   (ef),
      .convert_dst_rx_data       (data),
      .convert_dst_rx_padbytes   (pad),
      .dst_convert_rx_rdy        (rdy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rdy = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: rdy = 0;
            1: rdy = 1;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Every valid cycle must present the head of the expected queue; pop on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && val) begin
            if (sf && !start_seen) begin
               start_seen = 1;
               start_cyc  = cyc;
            end
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_beat: observed data %0h expected no output", data);
            end else begin
               e = expq[0];
               check("out_startframe", sf, e.sf);
               check("out_endframe", ef, e.ef);
               check("out_frame_size", fsize, e.fsize);
               check("out_data", data, e.data);
               check("out_padbytes", pad, e.pad);
               if (rdy) void'(expq.pop_front());
            end
         end
      end
   end

   task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input bit last,
                            input bit bad, input bit want_hi);
      bit acc = 0;
      int n   = 0;
      tvalid = 1;
      tdata  = d;
      tkeep  = k;
      tlast  = last;
      tuser  = bad;
      while (!acc && n < 2000) begin
         @(negedge clk);
         if (want_hi && n == 0) check("drop_tready_high", tready, 1);
         acc = tready;
         if (acc && last) tlast_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $error("FAIL ingress_timeout: observed tready low expected handshake in budget");
      end
      tvalid = 0;
      tlast  = 0;
      tuser  = 0;
   endtask

   task automatic send_frame(input int len, input bit bad, input bit seq, input bit want_hi);
      logic [7:0]   b[$];
      logic [511:0] d;
      logic [63:0]  k;
      exp_t         e;
      int nbeats = (len + 63) / 64;
      int nout   = (len + 31) / 32;
      for (int i = 0; i < len; i++) b.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
      if (!bad && len > 0 && len <= MTU) begin
         for (int o = 0; o < nout; o++) begin
            e.data = '0;
            for (int j = 0; j < 32; j++)
               if (o * 32 + j < len) e.data[255 - 8*j -: 8] = b[o*32 + j];
            e.sf    = (o == 0);
            e.ef    = (o == nout - 1);
            e.fsize = 16'(len);
            e.pad   = (o == nout - 1) ? 5'(nout * 32 - len) : 5'd0;
            expq.push_back(e);
         end
      end
      for (int bt = 0; bt < nbeats; bt++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 64; j++) begin
            if (bt * 64 + j < len) begin
               d[8*j +: 8] = b[bt*64 + j];
               k[j] = 1'b1;
            end
         end
         send_beat(d, k, bt == nbeats - 1, bad, want_hi);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("drain_empty", expq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_tready"}, tready, 0);
      check({tag, "_val"}, val, 0);
      check({tag, "_startframe"}, sf, 0);
      check({tag, "_endframe"}, ef, 0);
      check({tag, "_frame_size"}, fsize, 0);
      check({tag, "_data"}, data, 0);
      check({tag, "_padbytes"}, pad, 0);
   endtask

   initial begin
      logic [511:0] rd;
      int n;
      rst = 0; tvalid = 0; tdata = '0; tkeep = '0; tlast = 0; tuser = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1 rst = 1;

      // 64B sequential frame; startframe two cycles after the tlast cycle.
      start_seen = 0;
      send_frame(64, 0, 1, 0);
      drain();
      check("startframe_latency", start_cyc - tlast_cyc, 2);

      send_frame(100, 0, 0, 0);
      drain();

      // Bad frame is dropped; following 60B frame intact.
      send_frame(80, 1, 0, 0);
      send_frame(60, 0, 0, 0);
      drain();

      // Oversize frame: tready must stay high, nothing emitted.
      send_frame(2000, 0, 0, 1);
      send_frame(64, 0, 0, 0);
      drain();

      // Back-to-back frames with random downstream readiness.
      rdy_mode = 2;
      for (int f = 0; f < 10; f++) send_frame(128, 0, 0, 0);
      drain();

      // Reset mid-ingress while an output frame is stalled.
      rdy_mode = 0;
      send_frame(128, 0, 0, 0);
      n = 0;
      while (val !== 1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("pre_reset_val", val, 1);
      @(posedge clk);
      #1;
      for (int j = 0; j < 16; j++) rd[32*j +: 32] = $urandom;
      send_beat(rd, '1, 0, 0, 0);
      tvalid = 1;
      tdata  = ~rd;
      tkeep  = '1;
      rst    = 0;
      expq.delete();
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("mid_reset");
      @(posedge clk);
      #1 tvalid = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      rdy_mode = 1;
      send_frame(100, 0, 0, 0);
      drain();

      repeat (5) @(negedge clk);
      check("final_idle_val", val, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
